// File: rtl/pcm_spi_pkg.sv
// Shared types for the PCM-to-SPI streamer: FSM states, SPI mode and a
// helper that decides which SCK toggles advance the transmit shift register.
package pcm_spi_pkg;

   typedef enum logic [2:0] {
      st_idle,
      st_lead,
      st_shift,
      st_trail,
      st_gap
   } state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   // leading : this toggle moves SCK away from its idle level
   // first   : this is the very first toggle of the frame
   // CPHA=0 changes data on trailing edges (MSB is already on sdo during LEAD).
   // CPHA=1 changes data on leading edges, but the first leading edge only
   // exposes the MSB that was loaded, so it must not shift.
   function automatic logic is_shift_toggle(spi_mode_t mode, logic leading, logic first);
      logic shift;
      if (mode.cpha) begin
         shift = leading & ~first;
      end else begin
         shift = ~leading;
      end
      return shift;
   endfunction

endpackage

// File: rtl/pcm_frame_fifo.sv
// Frame FIFO: register-array storage, pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module pcm_frame_fifo
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_wr;
   logic             do_rd;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign full    = (level == FULL_LEVEL);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign do_rd   = rd_en & ~empty;
   // A write into a full FIFO is only honoured when a pop frees a slot in the same clk.
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   // Storage array; no reset so it maps onto plain memory.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   // Read and write pointers, free-running with wrap bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_rd) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pcm_spi_streamer.sv
// PCM frame streamer: buffers multi-channel sample frames and sends each one
// as a single SPI transaction (cs_n framed, MSB first, configurable mode).
// Each frame: LEAD half-period, 2N SCK toggles, TRAIL half-period, then
// GAP_HP half-periods with cs_n high before the next frame may start.
module pcm_spi_streamer
   import pcm_spi_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int CHANNELS   = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int CLK_DIV    = 4,
   parameter bit CPOL       = 1'b0,
   parameter bit CPHA       = 1'b0,
   parameter int GAP_HP     = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [CHANNELS*DATA_W-1:0]    s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic                          sck,
   output logic                          cs_n,
   output logic                          sdo,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic                          underrun
);

   localparam int N  = CHANNELS * DATA_W;
   localparam int CW = $clog2(CLK_DIV + 1);
   localparam int TW = $clog2(2 * N + 1);
   localparam int GW = $clog2(GAP_HP + 1);

   localparam logic [CW-1:0] HP_LAST  = CW'(CLK_DIV - 1);
   localparam logic [TW-1:0] TOG_LAST = TW'(2 * N);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HP - 1);
   localparam spi_mode_t     MODE     = '{cpol: CPOL, cpha: CPHA};

   // FIFO interface
   logic         fifo_wr;
   logic         fifo_rd;
   logic         fifo_full;
   logic         fifo_empty;
   logic [N-1:0] fifo_rd_data;

   // FSM and datapath state
   state_t       state_q,  state_d;
   logic [CW-1:0] hp_cnt_q, hp_cnt_d;
   logic [TW-1:0] tog_q,    tog_d;
   logic [TW-1:0] tog_inc;
   logic [GW-1:0] gap_q,    gap_d;
   logic [N-1:0]  shreg_q,  shreg_d;
   logic          sck_q,    sck_d;
   logic          cs_n_q,   cs_n_d;
   logic          underrun_q, underrun_d;
   logic          seen_q;
   logic          hp_done;
   logic          launch;

   // full is exactly level == FIFO_DEPTH, so this is level < FIFO_DEPTH.
   assign s_ready = ~fifo_full;
   assign fifo_wr = s_valid & s_ready;

   pcm_frame_fifo #(
      .WIDTH (N),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (fifo_wr),
      .wr_data (s_data),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign hp_done = (hp_cnt_q == HP_LAST);
   assign tog_inc = tog_q + 1'b1;

   // Next-state logic: half-period timing, SCK toggling, shifting and framing.
   always_comb begin
      state_d    = state_q;
      hp_cnt_d   = hp_cnt_q + 1'b1;
      tog_d      = tog_q;
      gap_d      = gap_q;
      shreg_d    = shreg_q;
      sck_d      = sck_q;
      cs_n_d     = cs_n_q;
      underrun_d = underrun_q;
      fifo_rd    = 1'b0;
      launch     = 1'b0;

      unique case (state_q)
         st_idle: begin
            hp_cnt_d = '0;
            sck_d    = MODE.cpol;
            cs_n_d   = 1'b1;
            launch   = ~fifo_empty;
         end

         st_lead: begin
            if (hp_done) begin
               hp_cnt_d = '0;
               state_d  = st_shift;
            end
         end

         st_shift: begin
            if (hp_done) begin
               hp_cnt_d = '0;
               sck_d    = ~sck_q;
               tog_d    = tog_inc;
               // Odd toggle numbers move SCK away from CPOL (leading edges).
               if (is_shift_toggle(MODE, tog_inc[0], tog_q == '0)) begin
                  shreg_d = shreg_q << 1;
               end
               if (tog_inc == TOG_LAST) begin
                  state_d = st_trail;
               end
            end
         end

         st_trail: begin
            if (hp_done) begin
               hp_cnt_d = '0;
               cs_n_d   = 1'b1;
               gap_d    = '0;
               state_d  = st_gap;
            end
         end

         st_gap: begin
            if (hp_done) begin
               hp_cnt_d = '0;
               gap_d    = gap_q + 1'b1;
               if (gap_q == GAP_LAST) begin
                  gap_d = '0;
                  if (!fifo_empty) begin
                     // Chain straight into the next frame so cs_n stays high
                     // for exactly GAP_HP half-periods between frames.
                     launch = 1'b1;
                  end else begin
                     state_d = st_idle;
                     if (seen_q) begin
                        underrun_d = 1'b1;
                     end
                  end
               end
            end
         end

         default: begin
            state_d = st_idle;
         end
      endcase

      if (launch) begin
         fifo_rd  = 1'b1;
         shreg_d  = fifo_rd_data;
         cs_n_d   = 1'b0;
         sck_d    = MODE.cpol;
         tog_d    = '0;
         hp_cnt_d = '0;
         state_d  = st_lead;
      end
   end

   // State registers; reset raises cs_n immediately and drops any frame in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= st_idle;
         hp_cnt_q   <= '0;
         tog_q      <= '0;
         gap_q      <= '0;
         shreg_q    <= '0;
         sck_q      <= MODE.cpol;
         cs_n_q     <= 1'b1;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hp_cnt_q   <= hp_cnt_d;
         tog_q      <= tog_d;
         gap_q      <= gap_d;
         shreg_q    <= shreg_d;
         sck_q      <= sck_d;
         cs_n_q     <= cs_n_d;
         underrun_q <= underrun_d;
      end
   end

   // Remembers that a frame was accepted, so underrun cannot fire before streaming starts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seen_q <= 1'b0;
      end else if (fifo_wr) begin
         seen_q <= 1'b1;
      end
   end

   // With CPHA=1 the MSB only appears on sdo at the first SCK edge.
   assign sdo      = ~cs_n_q & shreg_q[N-1] & (~MODE.cpha | (tog_q != '0));
   assign sck      = sck_q;
   assign cs_n     = cs_n_q;
   assign busy     = (state_q != st_idle);
   assign underrun = underrun_q;

endmodule

// File: tb/tb_pcm_spi_streamer.sv
// Bench for pcm_spi_streamer: three instances (default, mode 3 fast clock,
// single 24-bit channel). A negedge monitor captures sdo on SCK rising edges
// and pops the expected frame from a per-instance queue at each cs_n rise.
module tb_pcm_spi_streamer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance A: defaults
   logic [31:0] data_a = '0;
   logic        valid_a = 1'b0, ready_a, sck_a, cs_a, sdo_a, busy_a, und_a;
   logic [3:0]  level_a;
   // instance B: mode 3, CLK_DIV=1
   logic [31:0] data_b = '0;
   logic        valid_b = 1'b0, ready_b, sck_b, cs_b, sdo_b, busy_b, und_b;
   logic [3:0]  level_b;
   // instance C: one 24-bit channel
   logic [23:0] data_c = '0;
   logic        valid_c = 1'b0, ready_c, sck_c, cs_c, sdo_c, busy_c, und_c;
   logic [3:0]  level_c;

   pcm_spi_streamer u_a (
      .clk(clk), .reset_n(rst_n), .s_data(data_a), .s_valid(valid_a), .s_ready(ready_a),
      .sck(sck_a), .cs_n(cs_a), .sdo(sdo_a), .fifo_level(level_a), .busy(busy_a), .underrun(und_a));

   pcm_spi_streamer #(.CPOL(1'b1), .CPHA(1'b1), .CLK_DIV(1)) u_b (
      .clk(clk), .reset_n(rst_n), .s_data(data_b), .s_valid(valid_b), .s_ready(ready_b),
      .sck(sck_b), .cs_n(cs_b), .sdo(sdo_b), .fifo_level(level_b), .busy(busy_b), .underrun(und_b));

   pcm_spi_streamer #(.CHANNELS(1), .DATA_W(24)) u_c (
      .clk(clk), .reset_n(rst_n), .s_data(data_c), .s_valid(valid_c), .s_ready(ready_c),
      .sck(sck_c), .cs_n(cs_c), .sdo(sdo_c), .fifo_level(level_c), .busy(busy_c), .underrun(und_c));

   logic [2:0] sck_v, cs_v, sdo_v, ready_v, busy_v;
   assign sck_v   = {sck_c, sck_b, sck_a};
   assign cs_v    = {cs_c, cs_b, cs_a};
   assign sdo_v   = {sdo_c, sdo_b, sdo_a};
   assign ready_v = {ready_c, ready_b, ready_a};
   assign busy_v  = {busy_c, busy_b, busy_a};

   // scoreboard queues
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic [31:0] q_c[$];

   // monitor state
   int          nbits [3] = '{32, 32, 24};
   logic [31:0] cap [3];
   int          nb [3];
   int          low_cnt [3];
   int          high_cnt [3];
   int          last_low [3];
   int          last_high [3];
   int          frames [3];
   logic [2:0]  sck_p, cs_p;

   typedef struct {
      logic [31:0] data;
      int          low_clks;
      logic        und;
   } vec_t;
   vec_t vecs [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] lvl(input int i);
      logic [3:0] l;
      case (i)
         0:       l = level_a;
         1:       l = level_b;
         default: l = level_c;
      endcase
      return l;
   endfunction

   task automatic pop_exp(input int i, output logic [31:0] e, output bit ok);
      ok = 1'b1;
      e  = '0;
      case (i)
         0: if (q_a.size() > 0) e = q_a.pop_front(); else ok = 1'b0;
         1: if (q_b.size() > 0) e = q_b.pop_front(); else ok = 1'b0;
         default: if (q_c.size() > 0) e = q_c.pop_front(); else ok = 1'b0;
      endcase
   endtask

   task automatic frame_done(input int i);
      logic [31:0] e;
      bit ok;
      frames[i]++;
      last_low[i] = low_cnt[i];
      low_cnt[i]  = 0;
      pop_exp(i, e, ok);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL mon%0d_unexpected_frame actual=%0h required=none", i, cap[i]);
      end else begin
         check($sformatf("mon%0d_data", i), cap[i], e);
         check($sformatf("mon%0d_bits", i), nb[i], nbits[i]);
      end
      check($sformatf("mon%0d_sdo_after_cs", i), sdo_v[i], 1'b0);
      $display("mon%0d frame %0d captured=%0h bits=%0d cs_low_clks=%0d", i, frames[i], cap[i], nb[i], last_low[i]);
      cap[i] = '0;
      nb[i]  = 0;
   endtask

   // SPI monitor, sampled on the falling clk edge.
   initial begin
      for (int i = 0; i < 3; i++) begin
         cap[i] = '0; nb[i] = 0; low_cnt[i] = 0; high_cnt[i] = 0;
         last_low[i] = 0; last_high[i] = 0; frames[i] = 0;
      end
      sck_p = '0;
      cs_p  = '1;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
               cap[i] = '0; nb[i] = 0; low_cnt[i] = 0; high_cnt[i] = 0;
            end else if (!cs_v[i]) begin
               low_cnt[i]++;
               if (cs_p[i]) begin
                  last_high[i] = high_cnt[i];
                  high_cnt[i]  = 0;
               end
               if (sck_v[i] && !sck_p[i]) begin
                  cap[i] = {cap[i][30:0], sdo_v[i]};
                  nb[i]++;
               end
            end else begin
               high_cnt[i]++;
               if (!cs_p[i]) frame_done(i);
            end
         end
         sck_p = sck_v;
         cs_p  = cs_v;
      end
   end

   task automatic send(input int i, input logic [31:0] d);
      int t = 0;
      @(negedge clk);
      while (!ready_v[i] && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!ready_v[i]) check($sformatf("send%0d_ready_timeout", i), ready_v[i], 1'b1);
      case (i)
         0: begin data_a = d; valid_a = 1'b1; q_a.push_back(d); end
         1: begin data_b = d; valid_b = 1'b1; q_b.push_back(d); end
         default: begin data_c = d[23:0]; valid_c = 1'b1; q_c.push_back({8'h00, d[23:0]}); end
      endcase
      @(posedge clk);
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
      valid_c = 1'b0;
   endtask

   task automatic wait_idle(input int i, input int budget);
      int t = 0;
      @(negedge clk);
      while ((busy_v[i] || lvl(i) != 4'd0) && t < budget) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("idle%0d_timeout", i), busy_v[i], 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      q_a.delete();
      q_b.delete();
      q_c.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      int t;

      vecs[0] = '{32'hA5A5_3C3C, 264, 1'b1};
      vecs[1] = '{32'h0000_0000, 264, 1'b1};
      vecs[2] = '{32'hFFFF_FFFF, 264, 1'b1};
      vecs[3] = '{32'h8000_0001, 264, 1'b1};
      vecs[4] = '{32'h1234_5678, 264, 1'b1};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_sck_a", sck_a, 1'b0);
      check("rst_sck_b", sck_b, 1'b1);
      check("rst_cs", cs_v, 3'b111);
      check("rst_sdo", sdo_v, 3'b000);
      check("rst_ready", ready_v, 3'b111);
      check("rst_level_a", level_a, 4'd0);
      check("rst_busy", busy_v, 3'b000);
      check("rst_und", {und_c, und_b, und_a}, 3'b000);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("und_before_first_frame", und_a, 1'b0);

      // table-driven single frames on the default instance
      for (int k = 0; k < 5; k++) begin
         send(0, vecs[k].data);
         idle_inputs();
         wait_idle(0, 1000);
         check($sformatf("vec%0d_cs_low_clks", k), last_low[0], vecs[k].low_clks);
         check($sformatf("vec%0d_und", k), und_a, vecs[k].und);
         check($sformatf("vec%0d_sck_idle", k), sck_a, 1'b0);
         $display("vec %0d data=%0h cs_low=%0d und=%0b", k, vecs[k].data, last_low[0], und_a);
      end

      // two frames then none: gap length and underrun timing
      pulse_reset();
      check("gap_und_after_reset", und_a, 1'b0);
      send(0, 32'h0F0F_F0F0);
      send(0, 32'h1357_9BDF);
      idle_inputs();
      f0 = frames[0];
      t  = 0;
      while (frames[0] == f0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      repeat (12) @(negedge clk);
      check("gap_und_mid_stream", und_a, 1'b0);
      wait_idle(0, 1000);
      check("gap_cs_high_clks", last_high[0], 8);
      check("gap_und_set", und_a, 1'b1);

      // nine frames back-to-back while idle
      f0 = frames[0];
      for (int k = 0; k < 9; k++) send(0, 32'hC0DE_0000 + k);
      @(negedge clk);
      check("b2b_level_full", level_a, 4'd8);
      check("b2b_ready_low", ready_a, 1'b0);
      valid_a = 1'b0;
      wait_idle(0, 4000);
      check("b2b_frames_sent", frames[0] - f0, 9);
      check("b2b_queue_drained", q_a.size(), 0);

      // reset in the middle of a frame
      send(0, 32'hDEAD_BEEF);
      idle_inputs();
      t = 0;
      while (nb[0] < 10 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("mid_reset_reached_bit10", nb[0], 10);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_cs_async", cs_a, 1'b1);
      check("mid_reset_sdo", sdo_a, 1'b0);
      q_a.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_reset_level", level_a, 4'd0);
      check("mid_reset_und", und_a, 1'b0);
      check("mid_reset_busy", busy_a, 1'b0);
      repeat (300) @(negedge clk);
      check("mid_reset_stays_idle", cs_a, 1'b1);

      // mode 3, CLK_DIV=1
      send(1, 32'h8001_0001);
      idle_inputs();
      wait_idle(1, 300);
      check("m3_sck_rest", sck_b, 1'b1);
      check("m3_cs_low_clks", last_low[1], 66);

      // one 24-bit channel
      send(2, 32'h00FF_FFFF);
      idle_inputs();
      wait_idle(2, 1000);
      check("c1_cs_low_clks", last_low[2], 200);
      check("c1_sdo_idle", sdo_c, 1'b0);

      check("scoreboard_empty", q_a.size() + q_b.size() + q_c.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
